// File: rtl/alu_operand_entry.sv
// Operand entry front end for the 4-bit ALU: synchronises and debounces one push
// button, then steps through A, B, opcode captures from the board switches.
module alu_operand_entry #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic [3:0] sw,
  input  logic [2:0] sw_op,
  output logic [3:0] a_o,
  output logic [3:0] b_o,
  output logic [2:0] op_o,
  output logic [1:0] stage,
  output logic       valid,
  output logic       done
);

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_OP   = 2'd2,
    S_SHOW = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_m, btn_s;
  logic [3:0]       sw_m, sw_s;
  logic [2:0]       sw_op_m, sw_op_s;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             press;
  state_t           state;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_m   <= 1'b0;
      btn_s   <= 1'b0;
      sw_m    <= 4'd0;
      sw_s    <= 4'd0;
      sw_op_m <= 3'd0;
      sw_op_s <= 3'd0;
    end else begin
      btn_m   <= btn;
      btn_s   <= btn_m;
      sw_m    <= sw;
      sw_s    <= sw_m;
      sw_op_m <= sw_op;
      sw_op_s <= sw_op_m;
    end
  end

  // press rises together with stable on a 0->1 acceptance only; it is a
  // valid-only pulse (no ready) consumed by the FSM on the following edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (btn_s == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= btn_s;
        cnt    <= '0;
        press  <= btn_s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_A;
      a_o   <= 4'd0;
      b_o   <= 4'd0;
      op_o  <= 3'd0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (press) begin
        case (state)
          S_A: begin
            a_o   <= sw_s;
            state <= S_B;
          end
          S_B: begin
            b_o   <= sw_s;
            state <= S_OP;
          end
          S_OP: begin
            op_o  <= sw_op_s;
            state <= S_SHOW;
            done  <= 1'b1;
          end
          default: state <= S_A;
        endcase
      end
    end
  end

  assign stage = state;
  assign valid = (state == S_SHOW);

endmodule

// File: tb/tb_alu_operand_entry.sv
// Bench for alu_operand_entry: directed scenarios plus random button/switch
// activity, all outputs compared every cycle against a behavioural model.
module tb_alu_operand_entry;
  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic [3:0] sw;
  logic [2:0] sw_op;
  logic [3:0] a_o, b_o;
  logic [2:0] op_o;
  logic [1:0] stage;
  logic       valid, done;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  alu_operand_entry #(.DEBOUNCE_CYCLES(DEB), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .btn(btn), .sw(sw), .sw_op(sw_op),
    .a_o(a_o), .b_o(b_o), .op_o(op_o), .stage(stage), .valid(valid), .done(done)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: inputs reach the logic two edges late, a level is accepted
  // after DEB consecutive differing edges, and each accepted rise advances a
  // press counter whose position (mod 4) picks the slot that gets written.
  logic [14:0] exp_q[$];
  logic        m_btn_p[$] = '{1'b0, 1'b0};
  logic [3:0]  m_sw_p[$]  = '{4'd0, 4'd0};
  logic [2:0]  m_op_p[$]  = '{3'd0, 3'd0};
  logic        m_stable = 1'b0, m_press = 1'b0, m_done = 1'b0;
  int          m_run = 0, m_idx = 0;
  logic [3:0]  m_a = 4'd0, m_b = 4'd0;
  logic [2:0]  m_op = 3'd0;
  logic        bs, np;
  logic [3:0]  ss;
  logic [2:0]  os;

  always @(posedge clk) begin
    if (rst) begin
      m_btn_p = '{1'b0, 1'b0};
      m_sw_p  = '{4'd0, 4'd0};
      m_op_p  = '{3'd0, 3'd0};
      m_stable = 1'b0; m_press = 1'b0; m_done = 1'b0;
      m_run = 0; m_idx = 0;
      m_a = 4'd0; m_b = 4'd0; m_op = 3'd0;
    end else begin
      bs = m_btn_p.pop_front(); m_btn_p.push_back(btn);
      ss = m_sw_p.pop_front();  m_sw_p.push_back(sw);
      os = m_op_p.pop_front();  m_op_p.push_back(sw_op);
      m_done = 1'b0;
      if (m_press) begin
        if (m_idx == 0) m_a = ss;
        else if (m_idx == 1) m_b = ss;
        else if (m_idx == 2) m_op = os;
        m_done = (m_idx == 2);
        m_idx = (m_idx + 1) % 4;
      end
      np = 1'b0;
      if (bs != m_stable) begin
        m_run++;
        if (m_run == DEB) begin
          m_stable = bs;
          m_run = 0;
          np = bs;
        end
      end else begin
        m_run = 0;
      end
      m_press = np;
    end
    exp_q.push_back({m_a, m_b, m_op, 2'(m_idx), (m_idx == 3), m_done});
  end

  // scoreboard
  always @(negedge clk) begin
    logic [14:0] e;
    done_cnt += int'(done);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("a_o", a_o, e[14:11]);
      check("b_o", b_o, e[10:7]);
      check("op_o", op_o, e[6:4]);
      check("stage", stage, e[3:2]);
      check("valid", valid, e[1]);
      check("done", done, e[0]);
    end
  end

  // drivers
  task automatic do_reset(input int n);
    @(negedge clk); rst = 1'b1; btn = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic press(input logic [3:0] s, input logic [2:0] o, input logic [1:0] st_before);
    @(negedge clk); btn = 1'b1; sw = s; sw_op = o;
    repeat (DEB + 2) @(negedge clk);
    check("pre_capture_stage", stage, st_before);
    @(negedge clk);
    check("capture_stage", stage, 2'(st_before + 2'd1));
    repeat (3) @(negedge clk);
    btn = 1'b0;
    repeat (DEB + 6) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; btn = 1'b0; sw = 4'd0; sw_op = 3'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_a", a_o, 4'd0);
    check("rst_b", b_o, 4'd0);
    check("rst_op", op_o, 3'd0);
    check("rst_stage", stage, 2'd0);
    check("rst_valid", valid, 1'b0);
    check("rst_done", done, 1'b0);

    // full sequence
    press(4'b0101, 3'd6, 2'd0);
    press(4'b1101, 3'd2, 2'd1);
    done_cnt = 0;
    press(4'b0000, 3'b001, 2'd2);
    check("seq_a", a_o, 4'd5);
    check("seq_b", b_o, 4'd13);
    check("seq_op", op_o, 3'd1);
    check("seq_stage", stage, 2'd3);
    check("seq_valid", valid, 1'b1);
    check("seq_done_pulses", done_cnt, 1);

    // wrap from S_SHOW
    press(4'b1001, 3'd7, 2'd3);
    check("wrap_valid", valid, 1'b0);
    check("wrap_a_hold", a_o, 4'd5);
    check("wrap_b_hold", b_o, 4'd13);
    check("wrap_op_hold", op_o, 3'd1);
    press(4'b0011, 3'd0, 2'd0);
    check("wrap_a_new", a_o, 4'd3);
    check("wrap_b_old", b_o, 4'd13);

    // bounce rejection in S_A
    do_reset(2);
    sw = 4'd9;
    for (int i = 0; i < 3; i++) begin
      btn = 1'b1; repeat (3) @(negedge clk);
      btn = 1'b0; repeat (2) @(negedge clk);
    end
    repeat (DEB + 4) @(negedge clk);
    check("bounce_stage", stage, 2'd0);
    check("bounce_a", a_o, 4'd0);
    press(4'd7, 3'd0, 2'd0);
    check("clean_a", a_o, 4'd7);

    // held button in S_B
    @(negedge clk); btn = 1'b1; sw = 4'd10;
    repeat (50) @(negedge clk);
    check("held_stage", stage, 2'd2);
    check("held_b", b_o, 4'd10);
    sw = 4'd4;
    repeat (5) @(negedge clk);
    check("held_b_once", b_o, 4'd10);
    btn = 1'b0;
    repeat (DEB + 6) @(negedge clk);

    // reset mid-operation with button held
    btn = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_stage", stage, 2'd0);
    check("mid_rst_a", a_o, 4'd0);
    check("mid_rst_b", b_o, 4'd0);
    repeat (DEB + 2) @(negedge clk);
    check("mid_rst_pre", stage, 2'd0);
    @(negedge clk);
    check("mid_rst_press", stage, 2'd1);
    repeat (20) @(negedge clk);
    check("mid_rst_once", stage, 2'd1);
    btn = 1'b0;
    repeat (DEB + 6) @(negedge clk);

    // random activity
    for (int i = 0; i < 300; i++) begin
      btn = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 39) == 0);
      for (int k = $urandom_range(1, 2 * DEB); k > 0; k--) begin
        sw = 4'($urandom); sw_op = 3'($urandom);
        @(negedge clk);
        rst = 1'b0;
      end
    end
    btn = 1'b0;
    repeat (DEB + 6) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/alu_operand_entry.md
# alu_operand_entry

Sequential front end for the 4-bit ALU: it turns one raw push button plus board switches into a registered operand pair and opcode. It runs a three-press entry sequence: press 1 latches A, press 2 latches B, press 3 latches op. The button is synchronised and debounced first. The registered A/B/op drive the ALU's `A`, `B`, `op` inputs directly, and `stage` drives board LEDs so the user knows what the next press loads.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4; consecutive cycles the synchronised button must hold a new level before it is accepted; legal range 1..65535.
- `CNT_W`, default 16; debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES-1.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `btn`  in  1  raw push button, asynchronous, may bounce.
- `sw`  in  4  operand switches, asynchronous.
- `sw_op`  in  3  opcode switches, asynchronous.
- `a_o`  out  4  latched operand A.
- `b_o`  out  4  latched operand B.
- `op_o`  out  3  latched opcode.
- `stage`  out  2  current state encoding, for LEDs.
- `valid`  out  1  high while A, B and op form a complete set.
- `done`  out  1  one-cycle pulse on the cycle `valid` first rises.

## Operation
- **Synchronisers.** `btn`, `sw`, `sw_op` each pass through 2 flops. All logic below sees only synchronised values `btn_s`, `sw_s`, `sw_op_s`.
- **Debounce.** Registers: `stable` (accepted level) and `cnt`.
  - Each edge with `btn_s == stable`: `cnt <= 0`.
  - Each edge with `btn_s != stable` and `cnt < DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`.
  - Each edge with `btn_s != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable <= btn_s`, `cnt <= 0`.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `stable`.
- **Press.** `press` is a registered internal pulse. It is high for exactly the one cycle in which `stable` first reads 1 after a 0→1 acceptance. Release (1→0 acceptance) produces no pulse.
- **FSM.** States: S_A=0, S_B=1, S_OP=2, S_SHOW=3; `stage` equals the state code.
  - S_A: on `press`, `a_o <= sw_s`, go to S_B.
  - S_B: on `press`, `b_o <= sw_s`, go to S_OP.
  - S_OP: on `press`, `op_o <= sw_op_s`, go to S_SHOW, `done <= 1` for that one cycle.
  - S_SHOW: on `press`, go to S_A. `a_o`, `b_o`, `op_o` hold their values until each is overwritten by its own capture.
  - Without `press`, every state holds.
- **Outputs.** `valid` is combinational: state == S_SHOW. All other outputs are registered.
- **Arithmetic.** None on data; values pass through bit-exact, unsigned, with no extension. `sw` is interpreted by the downstream ALU as two's complement.

## Timing
- **Reset values** (reset applied on an edge with `rst`=1): sync flops 0, `stable`=0, `cnt`=0, state S_A, `a_o`=0, `b_o`=0, `op_o`=0, `stage`=0, `valid`=0, `done`=0, `press`=0.
- **Reset mid-sequence.** Any state returns to S_A and outputs clear on that edge.
- **Reset has priority** over a simultaneous `press`.
- **Button held through reset.** After reset release it is re-accepted as a new press after the normal latency. This is required behaviour.
- **Latency.** Let `btn` go high before edge 1 and stay high.
  - `btn_s`=1 after edge 2.
  - `stable` and `press` become 1 after edge 2+`DEBOUNCE_CYCLES`.
  - Capture is visible after edge 3+`DEBOUNCE_CYCLES`. With the default of 4, that is after edge 7.
- **Capture source.** The captured value is `sw_s` at the capture edge, i.e. `sw` as sampled two edges earlier.
- **Press rate.** At most one `press` per accepted low→high transition; holding the button never repeats.
- **Bounce.** A `btn` pulse that keeps `btn_s` high for fewer than `DEBOUNCE_CYCLES` consecutive cycles produces no state change.
- **`done` timing.** `done` coincides with the first cycle `valid`=1 and is never asserted outside that cycle.

## Test plan
- **Reset.** Assert `rst` 2 cycles with `btn`=0 → all outputs 0, `stage`=0, `valid`=0.
- **Full sequence** (`DEBOUNCE_CYCLES`=4). Press with `sw`=4'b0101, release; press with `sw`=4'b1101, release; press with `sw_op`=3'b001 → `a_o`=5, `b_o`=13, `op_o`=1, `stage`=3, `valid`=1, `done` high exactly 1 cycle. Each capture lands 7 edges after its `btn` rise.
- **Bounce rejection.** In S_A, toggle `btn` high 3 cycles / low 2 cycles, three times → `stage` stays 0, `a_o` stays 0. A clean 4+ cycle hold then advances to `stage`=1.
- **Held button.** Hold `btn` high 50 cycles in S_B → exactly one advance, to S_OP; `b_o` latched once.
- **Wrap.** From S_SHOW, press → `stage`=0, `valid`=0, `a_o`/`b_o`/`op_o` unchanged. Next press with `sw`=4'b0011 → `a_o`=3, `b_o` still old.
- **Reset mid-operation.** In S_OP with `btn` held high, pulse `rst` 1 cycle → state S_A, outputs 0. Then exactly one press is accepted 2+`DEBOUNCE_CYCLES` edges after reset release, giving `stage`=1.
